// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: decodes framed write/read/config
// commands, masters the register file, forwards read data to the UART TX.
module uart_rx_cmd_ctrl #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 4,
  parameter int unsigned           PRESCALE_WIDTH = 5,
  parameter int unsigned           RD_TIMEOUT     = 16,
  parameter logic [DATA_WIDTH-1:0] WR_CMD         = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD         = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CFG_CMD        = 8'hCC,
  parameter int unsigned           RST_PRESCALE   = 8,
  parameter logic                  RST_PAR_EN     = 1'b1,
  parameter logic                  RST_PAR_TYP    = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
  input  logic                      RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]     RF_RdData,
  input  logic                      RF_RdData_Valid,
  input  logic                      TX_Busy,
  output logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      PAR_EN,
  output logic                      PAR_TYP,
  output logic [ADDR_WIDTH-1:0]     RF_Address,
  output logic [DATA_WIDTH-1:0]     RF_WrData,
  output logic                      RF_WrEn,
  output logic                      RF_RdEn,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  output logic                      Busy,
  output logic                      Cmd_Err
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND,
    CFG_DATA
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [PRESCALE_WIDTH-1:0] prescale_nxt;
  logic                      par_en_nxt, par_typ_nxt;
  logic [ADDR_WIDTH-1:0]     addr_nxt;
  logic [DATA_WIDTH-1:0]     wr_data_nxt, tx_data_nxt;
  logic                      wr_en_nxt, rd_en_nxt, tx_vld_nxt, err_nxt;

  // Config byte layout: [4:0] prescale, [5] parity enable, [6] parity type.
  logic [4:0] cfg_pre;
  logic       cfg_ok;

  assign cfg_pre = RX_P_DATA[4:0];
  assign cfg_ok  = (cfg_pre == 5'd8) || (cfg_pre == 5'd16);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      Prescale   <= PRESCALE_WIDTH'(RST_PRESCALE);
      PAR_EN     <= RST_PAR_EN;
      PAR_TYP    <= RST_PAR_TYP;
      RF_Address <= '0;
      RF_WrData  <= '0;
      TX_P_DATA  <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      TX_D_VLD   <= 1'b0;
      Busy       <= 1'b0;
      Cmd_Err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      Prescale   <= prescale_nxt;
      PAR_EN     <= par_en_nxt;
      PAR_TYP    <= par_typ_nxt;
      RF_Address <= addr_nxt;
      RF_WrData  <= wr_data_nxt;
      TX_P_DATA  <= tx_data_nxt;
      RF_WrEn    <= wr_en_nxt;
      RF_RdEn    <= rd_en_nxt;
      TX_D_VLD   <= tx_vld_nxt;
      Busy       <= (state_nxt != IDLE);
      Cmd_Err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    prescale_nxt = Prescale;
    par_en_nxt   = PAR_EN;
    par_typ_nxt  = PAR_TYP;
    addr_nxt     = RF_Address;
    wr_data_nxt  = RF_WrData;
    tx_data_nxt  = TX_P_DATA;
    wr_en_nxt    = 1'b0;
    rd_en_nxt    = 1'b0;
    tx_vld_nxt   = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)       state_nxt = WR_ADDR;
          else if (RX_P_DATA == RD_CMD)  state_nxt = RD_ADDR;
          else if (RX_P_DATA == CFG_CMD) state_nxt = CFG_DATA;
          else                           err_nxt   = 1'b1;
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_nxt = WR_DATA;
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_nxt = RX_P_DATA;
          wr_en_nxt   = 1'b1;
          state_nxt   = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RD_WAIT;
        end
      end

      // Read data wins over timeout when both land on the last wait cycle.
      RD_WAIT: begin
        err_nxt = RX_D_VLD;
        if (RF_RdData_Valid) begin
          tx_data_nxt = RF_RdData;
          state_nxt   = TX_SEND;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      TX_SEND: begin
        err_nxt = RX_D_VLD;
        if (!TX_Busy) begin
          tx_vld_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end

      CFG_DATA: begin
        if (RX_D_VLD) begin
          if (cfg_ok) begin
            prescale_nxt = PRESCALE_WIDTH'(cfg_pre);
            par_en_nxt   = RX_P_DATA[5];
            par_typ_nxt  = RX_P_DATA[6];
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  a_one_strobe: assert property (@(posedge CLK) disable iff (!RST)
    $onehot0({RF_WrEn, RF_RdEn, TX_D_VLD}));

  a_busy_state: assert property (@(posedge CLK) disable iff (!RST)
    Busy == (state != IDLE));

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed protocol sequences, a config vector
// table, and randomized commands against a transaction-level model.
module tb_uart_rx_cmd_ctrl;

  localparam logic [7:0] WR = 8'hAA;
  localparam logic [7:0] RD = 8'hBB;
  localparam logic [7:0] CF = 8'hCC;
  localparam logic [7:0] MEM_INIT [16] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'hA5,
                                           8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F};

  logic       TX_CLK_TB = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RF_RdData = '0;
  logic       RF_RdData_Valid = 1'b0;
  logic       TX_Busy = 1'b0;
  logic [4:0] Prescale;
  logic       PAR_EN, PAR_TYP;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData, TX_P_DATA;
  logic       RF_WrEn, RF_RdEn, TX_D_VLD, Busy, Cmd_Err;

  uart_rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PRESCALE_WIDTH(5), .RD_TIMEOUT(16)) dut (
    .CLK(TX_CLK_TB), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid), .TX_Busy(TX_Busy),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .Busy(Busy), .Cmd_Err(Cmd_Err)
  );

  always #5 TX_CLK_TB = ~TX_CLK_TB;

  int cyc = 0;
  always @(posedge TX_CLK_TB) cyc <= cyc + 1;

  // Register-file model plus event monitor, sampled on the falling edge.
  logic [7:0] rf_mem [16] = MEM_INIT;
  int         rf_lat = 2;
  int         rf_cnt = 0;
  logic [3:0] rf_addr = '0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, excl_viol = 0;
  int wr_cyc = 0, rd_cyc = 0, tx_cyc = 0, err_cyc = 0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0, tx_data = '0;

  always @(negedge TX_CLK_TB) begin
    RF_RdData_Valid = 1'b0;
    if (!RST) begin
      rf_cnt = 0;
    end else begin
      if (rf_cnt != 0) begin
        rf_cnt = rf_cnt - 1;
        if (rf_cnt == 0) begin
          RF_RdData_Valid = 1'b1;
          RF_RdData = rf_mem[rf_addr];
        end
      end
      if (RF_RdEn) begin
        rd_cnt = rd_cnt + 1; rd_cyc = cyc; rd_addr = RF_Address;
        if (rf_lat != 0) begin rf_cnt = rf_lat; rf_addr = RF_Address; end
      end
      if (RF_WrEn) begin
        wr_cnt = wr_cnt + 1; wr_cyc = cyc; wr_addr = RF_Address; wr_data = RF_WrData;
        rf_mem[RF_Address] = RF_WrData;
      end
      if (TX_D_VLD) begin tx_cnt = tx_cnt + 1; tx_cyc = cyc; tx_data = TX_P_DATA; end
      if (Cmd_Err) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
      if (int'(RF_WrEn) + int'(RF_RdEn) + int'(TX_D_VLD) > 1) excl_viol = excl_viol + 1;
    end
  end

  int n_pass = 0, n_total = 0;
  int t_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    RX_P_DATA = b; RX_D_VLD = 1'b1; t_drv = cyc;
    @(negedge TX_CLK_TB);
    RX_D_VLD = 1'b0;
    repeat (gap) @(negedge TX_CLK_TB);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge TX_CLK_TB);
  endtask

  // Transaction-level reference state.
  logic [7:0] ref_mem [16];
  logic [4:0] ref_pre;
  logic       ref_pen, ref_ptyp;
  logic [7:0] ref_tx;

  typedef struct {
    logic [7:0] cfg;
    logic [4:0] pre;
    logic       pen;
    logic       ptyp;
    logic       err;
  } cfg_vec_t;
  cfg_vec_t tbl [10];

  initial begin
    int e0, w0, r0, t0, b0;
    logic [7:0] b, a, d;
    int lat, hold, kind;

    tbl[0] = '{8'h70, 5'd16, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h0C, 5'd16, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8'h08, 5'd8,  1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'hA8, 5'd8,  1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h50, 5'd16, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 5'd16, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{8'h18, 5'd16, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{8'h68, 5'd8,  1'b1, 1'b1, 1'b0};
    tbl[8] = '{8'h1F, 5'd8,  1'b1, 1'b1, 1'b1};
    tbl[9] = '{8'h48, 5'd8,  1'b0, 1'b1, 1'b0};
    ref_mem = MEM_INIT;

    // Reset state
    settle(3);
    RST = 1'b1;
    settle(2);
    check("rst_prescale", Prescale, 5'd8);
    check("rst_par_en", PAR_EN, 1'b1);
    check("rst_par_typ", PAR_TYP, 1'b0);
    check("rst_strobes", {RF_WrEn, RF_RdEn, TX_D_VLD, Cmd_Err}, 4'b0000);
    check("rst_busy", Busy, 1'b0);
    check("rst_data", {RF_Address, RF_WrData, TX_P_DATA}, 20'h0);

    // Write AA,03,5C
    w0 = wr_cnt;
    send_byte(WR, 0);
    check("wr_busy_mid", Busy, 1'b1);
    send_byte(8'h03, 1);
    send_byte(8'h5C, 0);
    check("wr_en_latency", RF_WrEn, 1'b1);
    settle(3);
    check("wr_count", wr_cnt - w0, 1);
    check("wr_cycle", wr_cyc, t_drv + 1);
    check("wr_addr", wr_addr, 4'h3);
    check("wr_data", wr_data, 8'h5C);
    check("wr_busy_after", Busy, 1'b0);
    ref_mem[3] = 8'h5C;

    // Read BB,07 with RF latency 2 and TX busy for ten cycles
    r0 = rd_cnt; t0 = tx_cnt; rf_lat = 2; TX_Busy = 1'b1;
    send_byte(RD, 2);
    send_byte(8'h07, 0);
    settle(9);
    TX_Busy = 1'b0; b0 = cyc;
    settle(4);
    check("rd_count", rd_cnt - r0, 1);
    check("rd_cycle", rd_cyc, t_drv + 1);
    check("rd_addr", rd_addr, 4'h7);
    check("rd_tx_count", tx_cnt - t0, 1);
    check("rd_tx_cycle", tx_cyc, b0 + 1);
    check("rd_tx_data", tx_data, 8'hA5);
    check("rd_tx_hold", TX_P_DATA, 8'hA5);

    // Read timeout with no response, then a write must still work
    e0 = err_cnt; t0 = tx_cnt; w0 = wr_cnt; rf_lat = 0;
    send_byte(RD, 0);
    send_byte(8'h02, 0);
    settle(25);
    check("to_err_count", err_cnt - e0, 1);
    check("to_err_cycle", err_cyc, rd_cyc + 16);
    check("to_no_tx", tx_cnt - t0, 0);
    check("to_tx_untouched", TX_P_DATA, 8'hA5);
    send_byte(WR, 0); send_byte(8'h01, 0); send_byte(8'h11, 0);
    settle(3);
    check("to_wr_after", {wr_addr, wr_data, 4'(wr_cnt - w0)}, {4'h1, 8'h11, 4'h1});
    ref_mem[1] = 8'h11;

    // Latency boundaries: last accepted wait cycle, and one cycle too late
    e0 = err_cnt; t0 = tx_cnt; rf_lat = 15;
    send_byte(RD, 0); send_byte(8'h09, 0);
    settle(22);
    check("lat15_tx", {4'(tx_cnt - t0), 4'(err_cnt - e0)}, 8'h10);
    check("lat15_tx_cycle", tx_cyc, rd_cyc + 17);
    check("lat15_data", tx_data, 8'hA9);
    e0 = err_cnt; t0 = tx_cnt; rf_lat = 16;
    send_byte(RD, 0); send_byte(8'h0A, 0);
    settle(22);
    check("lat16_err", {4'(tx_cnt - t0), 4'(err_cnt - e0)}, 8'h01);
    check("lat16_err_cycle", err_cyc, rd_cyc + 16);
    check("lat16_valid_ignored", TX_P_DATA, 8'hA9);

    // Byte arriving during the read wait is dropped; the read completes
    e0 = err_cnt; t0 = tx_cnt; w0 = wr_cnt; rf_lat = 8;
    send_byte(RD, 0); send_byte(8'h03, 2);
    send_byte(WR, 0);
    settle(15);
    check("drop_err", err_cnt - e0, 1);
    check("drop_tx", {4'(tx_cnt - t0), tx_data}, {4'h1, 8'h5C});
    send_byte(WR, 0); send_byte(8'h05, 0); send_byte(8'h66, 0);
    settle(3);
    check("drop_wr_after", {wr_addr, wr_data, 4'(wr_cnt - w0)}, {4'h5, 8'h66, 4'h1});
    ref_mem[5] = 8'h66;

    // Config vector table
    for (int i = 0; i < 10; i++) begin
      e0 = err_cnt;
      send_byte(CF, $urandom_range(0, 2));
      send_byte(tbl[i].cfg, 0);
      check($sformatf("cfg%0d_fields", i), {Prescale, PAR_EN, PAR_TYP},
            {tbl[i].pre, tbl[i].pen, tbl[i].ptyp});
      settle(2);
      check($sformatf("cfg%0d_err", i), err_cnt - e0, 32'(tbl[i].err));
      if (tbl[i].err) check($sformatf("cfg%0d_err_cycle", i), err_cyc, t_drv + 1);
    end

    // Unknown opcode
    e0 = err_cnt;
    send_byte(8'h12, 0);
    settle(2);
    check("badop_err", {4'(err_cnt - e0), 28'(err_cyc)}, {4'h1, 28'(t_drv + 1)});
    check("badop_idle", Busy, 1'b0);

    // Reset in the middle of a write
    w0 = wr_cnt;
    send_byte(WR, 0); send_byte(8'h04, 1);
    RST = 1'b0;
    settle(2);
    check("midrst_cfg", {Prescale, PAR_EN, PAR_TYP}, {5'd8, 1'b1, 1'b0});
    check("midrst_outs", {RF_Address, Busy, RF_WrEn}, 6'h0);
    RST = 1'b1;
    settle(1);
    e0 = err_cnt;
    send_byte(8'hFF, 0);
    settle(3);
    check("midrst_ff_err", err_cnt - e0, 1);
    check("midrst_no_wr", wr_cnt - w0, 0);

    // Randomized commands against the reference model
    ref_pre = 5'd8; ref_pen = 1'b1; ref_ptyp = 1'b0; ref_tx = 8'h00;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt;
      a = 8'($urandom); d = 8'($urandom);
      case (kind)
        0: begin
          send_byte(WR, $urandom_range(0, 3));
          send_byte(a, $urandom_range(0, 3));
          send_byte(d, 0);
          settle(3);
          check("rnd_wr", {4'(wr_cnt - w0), wr_addr, wr_data}, {4'h1, a[3:0], d});
          ref_mem[a[3:0]] = d;
        end
        1: begin
          lat = $urandom_range(1, 20); hold = $urandom_range(0, 20);
          rf_lat = lat; TX_Busy = (hold != 0);
          send_byte(RD, $urandom_range(0, 3));
          send_byte(a, 0);
          settle(hold);
          TX_Busy = 1'b0;
          settle(24);
          check("rnd_rd", {4'(rd_cnt - r0), rd_addr}, {4'h1, a[3:0]});
          if (lat >= 16) begin
            check("rnd_rd_timeout", {4'(err_cnt - e0), 4'(tx_cnt - t0), TX_P_DATA}, {4'h1, 4'h0, ref_tx});
          end else begin
            ref_tx = ref_mem[a[3:0]];
            check("rnd_rd_data", {4'(err_cnt - e0), 4'(tx_cnt - t0), tx_data}, {4'h0, 4'h1, ref_tx});
          end
        end
        2: begin
          b = 8'($urandom);
          if ($urandom_range(0, 1) == 1) b[4:0] = ($urandom_range(0, 1) == 1) ? 5'd8 : 5'd16;
          send_byte(CF, $urandom_range(0, 3));
          send_byte(b, 0);
          settle(2);
          if (b[4:0] == 5'd8 || b[4:0] == 5'd16) begin
            ref_pre = b[4:0]; ref_pen = b[5]; ref_ptyp = b[6];
            check("rnd_cfg_err", err_cnt - e0, 0);
          end else begin
            check("rnd_cfg_err", err_cnt - e0, 1);
          end
          check("rnd_cfg", {Prescale, PAR_EN, PAR_TYP}, {ref_pre, ref_pen, ref_ptyp});
        end
        default: begin
          b = 8'($urandom);
          if (b == WR || b == RD || b == CF) b = 8'h5A;
          send_byte(b, 0);
          settle(2);
          check("rnd_badop", {4'(err_cnt - e0), 4'(wr_cnt - w0), 4'(rd_cnt - r0)}, 12'h100);
        end
      endcase
      check("rnd_idle", Busy, 1'b0);
    end

    check("strobe_exclusive", excl_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
